// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the byte-lane mask helper used by bus responders.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Little-endian lane enables for an aligned transfer of 2^size bytes at lane offset off.
  function automatic logic [7:0] lane_mask(input logic [2:0] off, input logic [2:0] size);
    logic [7:0] m;
    case (size)
      HSIZE_BYTE: m = 8'h01;
      HSIZE_HALF: m = 8'h03;
      HSIZE_WORD: m = 8'h0f;
      default:    m = 8'hff;
    endcase
    return m << off;
  endfunction

endpackage

// File: rtl/ahb_slave_mem_ram.sv
// Single-port word memory: synchronous byte-enabled write, asynchronous read.
module ahb_slave_mem_ram #(
  parameter  int DW        = 32,
  parameter  int DEPTH     = 1024,
  localparam int NUM_LANES = DW / 8,
  localparam int IW        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [IW-1:0]        addr,
  input  logic [NUM_LANES-1:0] be,
  input  logic [DW-1:0]        wdata,
  output logic [DW-1:0]        rdata
);

  logic [NUM_LANES-1:0][7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++)
      if (we && be[i]) mem[addr][i] <= wdata[8*i +: 8];
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory responder with fixed wait states and a two-cycle ERROR for illegal transfers.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int AHB_DW      = 32,
  parameter int AHB_AW      = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hsel,
  input  logic [AHB_AW-1:0] haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [AHB_DW-1:0] hwdata,
  input  logic              hready,
  output logic              hreadyout,
  output logic              hresp,
  output logic [AHB_DW-1:0] hrdata,
  output logic              hexokay
);

  localparam int NUM_LANES = AHB_DW / 8;
  localparam int OFF       = $clog2(NUM_LANES);
  localparam int IW        = $clog2(MEM_DEPTH);
  localparam logic [AHB_AW:0] MEM_BYTES = (AHB_AW+1)'(MEM_DEPTH * NUM_LANES);
  localparam logic [3:0]      WS        = 4'(WAIT_STATES);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t            state;
  logic [3:0]        wait_cnt;
  logic [AHB_AW-1:0] dp_addr;
  logic              dp_write;
  logic [2:0]        dp_size;
  logic [AHB_DW-1:0] hrdata_q, ram_rdata;
  logic [7:0]        be8;
  logic [6:0]        align_mask;
  logic              accept, illegal, ram_we, rd_phase;
  logic              unused;

  assign accept     = hsel && hready && (htrans_t'(htrans) inside {HTRANS_NONSEQ, HTRANS_SEQ});
  assign align_mask = 7'((8'd1 << hsize) - 8'd1);
  assign illegal    = ({1'b0, haddr} >= MEM_BYTES) || (|(haddr[6:0] & align_mask))
                   || (hsize > 3'(OFF));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
      wait_cnt  <= 4'd0;
      hrdata_q  <= '0;
    end else begin
      if (rd_phase) hrdata_q <= ram_rdata;
      case (state)
        S_WAIT: begin
          if (wait_cnt == 4'd1) begin
            state     <= S_DATA;
            hreadyout <= 1'b1;
            wait_cnt  <= 4'd0;
          end else begin
            wait_cnt  <= wait_cnt - 4'd1;
          end
        end
        S_ERR1: begin
          state     <= S_ERR2;
          hreadyout <= 1'b1;
          hresp     <= HRESP_ERROR;
        end
        default: begin
          // IDLE, DATA and ERR2 all present a ready cycle, so each can take a new address phase.
          state     <= S_IDLE;
          hreadyout <= 1'b1;
          hresp     <= HRESP_OKAY;
          if (accept) begin
            dp_addr  <= haddr;
            dp_write <= hwrite;
            dp_size  <= hsize;
            if (illegal) begin
              state     <= S_ERR1;
              hreadyout <= 1'b0;
              hresp     <= HRESP_ERROR;
            end else if (WS != 4'd0) begin
              state     <= S_WAIT;
              hreadyout <= 1'b0;
              wait_cnt  <= WS;
            end else begin
              state     <= S_DATA;
            end
          end
        end
      endcase
    end
  end

  // A write commits on the edge that ends its data phase, so a read data phase that
  // immediately follows already sees the merged word through the asynchronous read.
  assign ram_we   = (state == S_DATA) && dp_write && !reset;
  assign rd_phase = (state == S_DATA) && !dp_write;
  assign be8      = lane_mask(3'(dp_addr[OFF-1:0]), dp_size);

  ahb_slave_mem_ram #(.DW(AHB_DW), .DEPTH(MEM_DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (dp_addr[OFF +: IW]),
    .be    (be8[NUM_LANES-1:0]),
    .wdata (hwdata),
    .rdata (ram_rdata)
  );

  assign hrdata  = rd_phase ? ram_rdata : hrdata_q;
  assign hexokay = 1'b0;
  assign unused  = ^{hburst, dp_addr, be8};

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench for ahb_slave_mem: three responders (0, 3 and 4 wait states) against a byte-array model.
module tb_ahb_slave_mem;

  logic             clk, reset;
  logic [2:0]       hsel_v;
  logic [31:0]      haddr, hwdata;
  logic [1:0]       htrans;
  logic             hwrite;
  logic [2:0]       hsize, hburst;
  logic [2:0]       rdy, resp, exok;
  logic [2:0][31:0] rdat;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mb [3][256];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb_slave_mem #(.AHB_DW(32), .AHB_AW(32), .MEM_DEPTH(64),
                    .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 3 : 4))) u_dut (
      .clk(clk), .reset(reset), .hsel(hsel_v[g]), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
      .hready(rdy[g]), .hreadyout(rdy[g]), .hresp(resp[g]), .hrdata(rdat[g]),
      .hexokay(exok[g]));
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 400000");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit legal(input logic [31:0] a, input logic [2:0] s);
    return (a < 32'd256) && ((a % (32'd1 << s)) == 0) && (s <= 3'd2);
  endfunction

  function automatic logic [31:0] mword(input int k, input logic [31:0] a);
    int b;
    b = int'(a) & ~3;
    return {mb[k][b+3], mb[k][b+2], mb[k][b+1], mb[k][b]};
  endfunction

  task automatic mwrite(input int k, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    for (int i = 0; i < (1 << s); i++)
      mb[k][int'(a) + i] = d[8*(int'(a % 4) + i) +: 8];
  endtask

  // Non-pipelined transfer to DUT k; returns the ready-cycle data and response.
  task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [2:0] s,
                      input logic [31:0] d, output logic [31:0] rd, output int waits,
                      output bit first_resp, output bit last_resp, output bit to);
    hsel_v = 3'(1 << k); haddr = a; hwrite = wr; hsize = s; htrans = 2'd2;
    step();
    hsel_v = '0; htrans = 2'd0; hwdata = d;
    waits = 0; to = 1'b1; rd = '0; first_resp = 1'b0; last_resp = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) first_resp = resp[k];
      if (rdy[k]) begin
        rd = rdat[k]; last_resp = resp[k]; to = 1'b0;
        step();
        break;
      end
      waits++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; hsel_v = '0; haddr = '0; htrans = 2'd0; hwrite = 1'b0;
    hsize = 3'd2; hburst = 3'd0; hwdata = '0;
    repeat (3) step();
    @(negedge clk);
    n_tests++;
    if (rdy !== 3'b111 || resp !== 3'b000 || exok !== 3'b000 || rdat !== '0) begin
      n_fail++;
      $display("FAIL reset_state: rdy=%b resp=%b exok=%b rdat=%h, required 111/000/000/0", rdy, resp, exok, rdat);
    end
    step();
    reset = 1'b0;
  endtask

  task automatic preload();
    logic [31:0] rd; int w; bit f, l, to;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 64; i++) begin
        xfer(k, 1'b1, 32'(i * 4), 3'd2, 32'h0, rd, w, f, l, to);
        mwrite(k, 32'(i * 4), 3'd2, 32'h0);
      end
  endtask

  task automatic test_back_to_back();
    bit p_wr; logic [31:0] p_a, p_d; logic [2:0] p_s; bit have;
    bit c_wr; logic [31:0] c_a, c_d; logic [2:0] c_s;
    // Directed: write then read of the same word, no gap.
    hsel_v = 3'b001; haddr = 32'h10; hwrite = 1'b1; hsize = 3'd2; htrans = 2'd2;
    step();
    hwrite = 1'b0; hwdata = 32'hDEADBEEF;
    @(negedge clk);
    n_tests++;
    if (rdy[0] !== 1'b1 || resp[0] !== 1'b0) begin
      n_fail++; $display("FAIL b2b_write_phase: rdy=%b resp=%b, required 1/0", rdy[0], resp[0]);
    end
    mwrite(0, 32'h10, 3'd2, 32'hDEADBEEF);
    step();
    hsel_v = '0; htrans = 2'd0;
    @(negedge clk);
    n_tests++;
    if (rdy[0] !== 1'b1 || resp[0] !== 1'b0 || rdat[0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL b2b_raw_read: rdy=%b resp=%b data=%h, required 1/0/deadbeef", rdy[0], resp[0], rdat[0]);
    end
    step();
    // Random pipelined stream in a small window so same-word read-after-write is frequent.
    have = 1'b0; p_wr = 1'b0; p_a = '0; p_d = '0; p_s = '0;
    for (int i = 0; i <= 200; i++) begin
      c_s = 3'($urandom_range(0, 2));
      c_a = 32'($urandom_range(0, 31)) & ~((32'd1 << c_s) - 32'd1);
      c_wr = 1'($urandom_range(0, 1));
      c_d = $urandom;
      if (i < 200) begin
        hsel_v = 3'b001; haddr = c_a; hsize = c_s; hwrite = c_wr;
        htrans = 2'($urandom_range(2, 3));
      end else begin
        hsel_v = '0; htrans = 2'd0;
      end
      hwdata = p_d;
      @(negedge clk);
      if (have) begin
        n_tests++;
        if (rdy[0] !== 1'b1 || resp[0] !== 1'b0) begin
          n_fail++; $display("FAIL b2b_ready_%0d: rdy=%b resp=%b, required 1/0", i, rdy[0], resp[0]);
        end
        if (p_wr) mwrite(0, p_a, p_s, p_d);
        else begin
          n_tests++;
          if (rdat[0] !== mword(0, p_a)) begin
            n_fail++;
            $display("FAIL b2b_read_%0d: addr=%h data=%h, required %h", i, p_a, rdat[0], mword(0, p_a));
          end
        end
      end
      step();
      p_wr = c_wr; p_a = c_a; p_d = c_d; p_s = c_s; have = (i < 200);
    end
  endtask

  task automatic test_wait();
    logic [31:0] rd, a, d; logic [2:0] s; int w; bit f, l, to, wr;
    xfer(1, 1'b1, 32'h0, 3'd2, 32'h600DF00D, rd, w, f, l, to);
    mwrite(1, 32'h0, 3'd2, 32'h600DF00D);
    xfer(1, 1'b0, 32'h0, 3'd2, 32'h0, rd, w, f, l, to);
    n_tests++;
    if (to || w != 3 || l !== 1'b0 || rd !== mword(1, 32'h0)) begin
      n_fail++;
      $display("FAIL wait3_read: to=%0b waits=%0d resp=%b data=%h, required 0/3/0/%h", to, w, l, rd, mword(1, 32'h0));
    end
    for (int i = 0; i < 10; i++) begin
      s = 3'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 255)) & ~((32'd1 << s) - 32'd1);
      wr = 1'($urandom_range(0, 1));
      d = $urandom;
      xfer(1, wr, a, s, d, rd, w, f, l, to);
      n_tests++;
      if (to || w != 3 || l !== 1'b0 || (!wr && rd !== mword(1, a))) begin
        n_fail++;
        $display("FAIL wait3_rand_%0d: to=%0b waits=%0d resp=%b data=%h, required 0/3/0/%h", i, to, w, l, rd, mword(1, a));
      end
      if (wr) mwrite(1, a, s, d);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; int w; bit f, l, to;
    xfer(0, 1'b1, 32'h10, 3'd2, 32'h0, rd, w, f, l, to);          mwrite(0, 32'h10, 3'd2, 32'h0);
    xfer(0, 1'b1, 32'h13, 3'd0, 32'hAA000000, rd, w, f, l, to);   mwrite(0, 32'h13, 3'd0, 32'hAA000000);
    xfer(0, 1'b1, 32'h10, 3'd1, 32'h00005566, rd, w, f, l, to);   mwrite(0, 32'h10, 3'd1, 32'h00005566);
    xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, w, f, l, to);
    n_tests++;
    if (to || rd !== 32'hAA005566) begin
      n_fail++; $display("FAIL byte_lanes: data=%h, required aa005566", rd);
    end
  endtask

  task automatic test_error();
    logic [31:0] rd, prev; int w; bit f, l, to;
    logic [31:0] ea [4] = '{32'h2, 32'd256, 32'h8, 32'h1};
    logic [2:0]  es [4] = '{3'd2, 3'd2, 3'd3, 3'd1};
    bit          ew [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    xfer(1, 1'b0, 32'h4, 3'd2, 32'h0, prev, w, f, l, to);
    for (int i = 0; i < 4; i++) begin
      xfer(1, ew[i], ea[i], es[i], 32'hFFFFFFFF, rd, w, f, l, to);
      n_tests++;
      if (legal(ea[i], es[i]) || to || w != 1 || f !== 1'b1 || l !== 1'b1 || rd !== prev) begin
        n_fail++;
        $display("FAIL error_%0d: to=%0b waits=%0d resp=%b,%b data=%h, required 0/1/1,1/%h", i, to, w, f, l, rd, prev);
      end
    end
    for (int i = 0; i < 3; i++) begin
      xfer(1, 1'b0, 32'(i * 4), 3'd2, 32'h0, rd, w, f, l, to);
      n_tests++;
      if (rd !== mword(1, 32'(i * 4))) begin
        n_fail++; $display("FAIL error_mem_%0d: data=%h, required %h", i, rd, mword(1, 32'(i * 4)));
      end
    end
  endtask

  task automatic test_no_access();
    logic [31:0] rd; int w; bit f, l, to;
    logic [2:0] sel [3] = '{3'b001, 3'b001, 3'b000};
    logic [1:0] tr  [3] = '{2'd1, 2'd0, 2'd2};
    for (int i = 0; i < 3; i++) begin
      hsel_v = sel[i]; htrans = tr[i]; haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2;
      hwdata = 32'hFFFFFFFF;
      step();
      hsel_v = '0; htrans = 2'd0;
      @(negedge clk);
      n_tests++;
      if (rdy[0] !== 1'b1 || resp[0] !== 1'b0) begin
        n_fail++; $display("FAIL no_access_%0d: rdy=%b resp=%b, required 1/0", i, rdy[0], resp[0]);
      end
      step();
    end
    xfer(0, 1'b0, 32'h20, 3'd2, 32'h0, rd, w, f, l, to);
    n_tests++;
    if (rd !== mword(0, 32'h20)) begin
      n_fail++; $display("FAIL no_access_mem: data=%h, required %h", rd, mword(0, 32'h20));
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; int w; bit f, l, to;
    xfer(2, 1'b1, 32'h24, 3'd2, 32'h12345678, rd, w, f, l, to);
    mwrite(2, 32'h24, 3'd2, 32'h12345678);
    xfer(2, 1'b0, 32'h24, 3'd2, 32'h0, rd, w, f, l, to);
    n_tests++;
    if (to || w != 4 || rd !== 32'h12345678) begin
      n_fail++; $display("FAIL wait4_read: waits=%0d data=%h, required 4/12345678", w, rd);
    end
    hsel_v = 3'b100; haddr = 32'h24; hwrite = 1'b1; hsize = 3'd2; htrans = 2'd2;
    step();
    hsel_v = '0; htrans = 2'd0; hwdata = 32'hCAFEF00D;
    @(negedge clk);
    n_tests++;
    if (rdy[2] !== 1'b0) begin
      n_fail++; $display("FAIL wait4_first: rdy=%b, required 0", rdy[2]);
    end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (rdy[2] !== 1'b1 || resp[2] !== 1'b0 || rdat[2] !== 32'h0 || exok[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_wait: rdy=%b resp=%b data=%h, required 1/0/0", rdy[2], resp[2], rdat[2]);
    end
    step();
    xfer(2, 1'b0, 32'h24, 3'd2, 32'h0, rd, w, f, l, to);
    n_tests++;
    if (rd !== mword(2, 32'h24)) begin
      n_fail++; $display("FAIL reset_abort_write: data=%h, required %h", rd, mword(2, 32'h24));
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_back_to_back();
    test_wait();
    test_byte_lanes();
    test_error();
    test_no_access();
    test_reset_mid_wait();
    @(negedge clk);
    n_tests++;
    if (exok !== 3'b000) begin
      n_fail++; $display("FAIL hexokay: exok=%b, required 000", exok);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
